// File: rtl/instr_mem_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : LoaderTypes (package)
//  Description : Shared types and constants for the instruction memory
//                loader: FSM state encoding and word geometry.
//  Revision    : 1.0 - initial release
// ============================================================================
package LoaderTypes;

    // Loader FSM states; CHECK is only reachable with LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        WRITE   = 3'd2,
        CHECK   = 3'd3,
        DONE    = 3'd4
    } LoaderState_t;

    // Bytes in one instruction word and the width of the byte index
    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_IDX_WIDTH = 2;

endpackage : LoaderTypes
`default_nettype wire

// File: rtl/instr_mem_loader_word_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : word_assembler
//  Description : Little-endian byte-to-word shift-in register. Bytes 0..2 are
//                stored; byte 3 is passed straight through so the complete
//                word is presented together with oWordValid in the cycle the
//                fourth byte is accepted.
//  Revision    : 1.0 - initial release
// ============================================================================
module word_assembler
    import LoaderTypes::*;
(
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iClear,
    input  logic [7:0]  iByte,
    input  logic        iByteAccept,
    output logic [31:0] oWord,
    output logic        oWordValid
);

    logic [BYTE_IDX_WIDTH-1:0] r_idx;
    logic [23:0]               r_shift;

    // Store bytes 0..2 at their little-endian lanes; the index wraps after byte 3
    always_ff @(posedge iClk) begin
        if (iRst || iClear) begin
            r_idx   <= '0;
            r_shift <= '0;
        end else if (iByteAccept) begin
            case (r_idx)
                2'd0:    r_shift[7:0]   <= iByte;
                2'd1:    r_shift[15:8]  <= iByte;
                2'd2:    r_shift[23:16] <= iByte;
                default: ;  // byte 3 leaves directly through oWord
            endcase
            r_idx <= r_idx + 2'd1;
        end
    end

    assign oWord      = {iByte, r_shift};
    assign oWordValid = iByteAccept && (r_idx == 2'd3);

endmodule : word_assembler
`default_nettype wire

// File: rtl/instr_mem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : instr_mem_loader
//  Description : Write-side master for the instruction memory. After a start
//                command it assembles a byte stream into little-endian 32-bit
//                words and writes them to consecutive word addresses, holding
//                the CPU off while the load is in progress.
//                Optional feature macro: LOADER_CHECKSUM_EN - appends a 4-byte
//                little-endian checksum (sum of written words, mod 2^32) after
//                the last word and flags a mismatch on oChecksumErr.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_mem_loader
    import LoaderTypes::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   iClk,
    input  logic                   iRst,
    input  logic                   iStart,
    input  logic [ADDR_WIDTH-1:0]  iBaseAddr,
    input  logic [COUNT_WIDTH-1:0] iWordCount,
    input  logic [7:0]             iByte,
    input  logic                   iByteValid,
    output logic                   oByteReady,
    output logic                   oMemWe,
    output logic [ADDR_WIDTH-1:0]  oMemAddr,
    output logic [31:0]            oMemWData,
    output logic                   oBusy,
    output logic                   oCpuHold,
    output logic                   oDone,
    output logic                   oChecksumErr
);

    localparam logic [ADDR_WIDTH-1:0] c_WORD_STRIDE = ADDR_WIDTH'(BYTES_PER_WORD);
    localparam logic [ADDR_WIDTH-1:0] c_ALIGN_MASK  = ~(c_WORD_STRIDE - ADDR_WIDTH'(1));

    LoaderState_t           r_state;
    logic [COUNT_WIDTH-1:0] r_count;
    logic [COUNT_WIDTH-1:0] r_word_idx;
    logic [ADDR_WIDTH-1:0]  r_next_addr;
    logic [ADDR_WIDTH-1:0]  r_mem_addr;
    logic [31:0]            r_mem_wdata;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0]            r_sum;
    logic                   r_chk_err;
`endif

    logic                   w_start_accept;
    logic                   w_byte_ready;
    logic                   w_byte_accept;
    logic                   w_asm_clear;
    logic                   w_word_valid;
    logic [31:0]            w_word;
    logic [COUNT_WIDTH-1:0] w_idx_next;

    // Start is only honoured in IDLE; it also restarts the byte assembler
    assign w_start_accept = iStart && (r_state == IDLE);
    assign w_byte_ready   = (r_state == COLLECT) || (r_state == CHECK);
    assign w_byte_accept  = iByteValid && w_byte_ready;
    assign w_asm_clear    = iRst || w_start_accept;
    assign w_idx_next     = r_word_idx + COUNT_WIDTH'(1);

    // Shared byte assembler: builds instruction words and, later, the checksum word
    word_assembler u_word_asm (
        .iClk        (iClk),
        .iRst        (iRst),
        .iClear      (w_asm_clear),
        .iByte       (iByte),
        .iByteAccept (w_byte_accept),
        .oWord       (w_word),
        .oWordValid  (w_word_valid)
    );

    // Load sequencer: captures the command, issues one write per assembled word
    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_state     <= IDLE;
            r_count     <= '0;
            r_word_idx  <= '0;
            r_next_addr <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
`ifdef LOADER_CHECKSUM_EN
            r_sum       <= '0;
            r_chk_err   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (iStart) begin
                        // Low address bits are forced to zero so every write is word aligned
                        r_next_addr <= iBaseAddr & c_ALIGN_MASK;
                        r_count     <= iWordCount;
                        r_word_idx  <= '0;
`ifdef LOADER_CHECKSUM_EN
                        r_sum       <= '0;
                        r_chk_err   <= 1'b0;
`endif
                        r_state     <= (iWordCount == '0) ? DONE : COLLECT;
                    end
                end

                COLLECT: begin
                    // Address and data are latched here so they hold outside WRITE
                    if (w_word_valid) begin
                        r_mem_wdata <= w_word;
                        r_mem_addr  <= r_next_addr;
                        r_state     <= WRITE;
                    end
                end

                WRITE: begin
                    r_word_idx  <= w_idx_next;
                    r_next_addr <= r_next_addr + c_WORD_STRIDE;
`ifdef LOADER_CHECKSUM_EN
                    r_sum       <= r_sum + r_mem_wdata;
                    r_state     <= (w_idx_next == r_count) ? CHECK : COLLECT;
`else
                    r_state     <= (w_idx_next == r_count) ? DONE : COLLECT;
`endif
                end

`ifdef LOADER_CHECKSUM_EN
                CHECK: begin
                    // The accumulator already includes the last word once CHECK is entered
                    if (w_word_valid) begin
                        r_chk_err <= (w_word != r_sum);
                        r_state   <= DONE;
                    end
                end
`endif

                DONE: begin
                    r_state <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign oByteReady = w_byte_ready;
    assign oMemWe     = (r_state == WRITE);
    assign oMemAddr   = r_mem_addr;
    assign oMemWData  = r_mem_wdata;
    assign oBusy      = (r_state != IDLE);
    assign oCpuHold   = (r_state != IDLE);
    assign oDone      = (r_state == DONE);
`ifdef LOADER_CHECKSUM_EN
    assign oChecksumErr = r_chk_err;
`else
    assign oChecksumErr = 1'b0;
`endif

endmodule : instr_mem_loader
`default_nettype wire

// File: tb/tb_instr_mem_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_instr_mem_loader
//  Description : Self-checking bench for instr_mem_loader. Directed and
//                randomised loads are compared against a word-list reference
//                model (expected addresses, data, latency and checksum flag).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_mem_loader;

    localparam int AW = 32;
    localparam int CW = 16;

    logic          iClk       = 1'b0;
    logic          iRst       = 1'b1;
    logic          iStart     = 1'b0;
    logic [AW-1:0] iBaseAddr  = '0;
    logic [CW-1:0] iWordCount = '0;
    logic [7:0]    iByte      = '0;
    logic          iByteValid = 1'b0;
    logic          oByteReady;
    logic          oMemWe;
    logic [AW-1:0] oMemAddr;
    logic [31:0]   oMemWData;
    logic          oBusy;
    logic          oCpuHold;
    logic          oDone;
    logic          oChecksumErr;

    instr_mem_loader #(.ADDR_WIDTH(AW), .COUNT_WIDTH(CW)) dut (
        .iClk         (iClk),
        .iRst         (iRst),
        .iStart       (iStart),
        .iBaseAddr    (iBaseAddr),
        .iWordCount   (iWordCount),
        .iByte        (iByte),
        .iByteValid   (iByteValid),
        .oByteReady   (oByteReady),
        .oMemWe       (oMemWe),
        .oMemAddr     (oMemAddr),
        .oMemWData    (oMemWData),
        .oBusy        (oBusy),
        .oCpuHold     (oCpuHold),
        .oDone        (oDone),
        .oChecksumErr (oChecksumErr)
    );

    always #5 iClk = ~iClk;

    int          checks   = 0;
    int          errors   = 0;
    int unsigned cyc      = 0;
    int          done_cnt = 0;
    logic [31:0] obs_addr[$];
    logic [31:0] obs_data[$];
    logic [31:0] ld_words[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Edge counter used for latency measurement
    initial forever begin
        @(posedge iClk);
        cyc++;
    end

    // Write monitor: records every memory write and counts done pulses
    initial forever begin
        @(negedge iClk);
        if (!iRst) begin
            if (oMemWe) begin
                obs_addr.push_back(oMemAddr);
                obs_data.push_back(oMemWData);
                chk("ready_in_write", 64'(oByteReady), 64'd0);
                chk("hold_in_write", 64'(oCpuHold), 64'd1);
            end
            if (oDone) done_cnt++;
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok;
        ok = 1'b0;
        iByteValid = 1'b0;
        repeat (gap) begin
            @(posedge iClk);
            #1;
        end
        iByte      = b;
        iByteValid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(negedge iClk);
            if (oByteReady) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("byte_timeout", 64'd0, 64'd1);
        @(posedge iClk);
        #1;
        iByteValid = 1'b0;
    endtask

    task automatic check_all_zero(input string pfx);
        chk({pfx, "_we"},    64'(oMemWe),       64'd0);
        chk({pfx, "_addr"},  64'(oMemAddr),     64'd0);
        chk({pfx, "_wdata"}, 64'(oMemWData),    64'd0);
        chk({pfx, "_busy"},  64'(oBusy),        64'd0);
        chk({pfx, "_hold"},  64'(oCpuHold),     64'd0);
        chk({pfx, "_done"},  64'(oDone),        64'd0);
        chk({pfx, "_ready"}, 64'(oByteReady),   64'd0);
        chk({pfx, "_cksum"}, 64'(oChecksumErr), 64'd0);
    endtask

    // One complete load of ld_words, checked against the word-list model
    task automatic run_load(input logic [31:0] base, input int max_gap,
                            input bit bad_sum, input bit poke_start);
        int          n;
        logic [31:0] sum;
        logic [31:0] exp_addr;
        int unsigned start_cyc;
        int unsigned done_cyc;
        bit          got_done;
        int          exp_lat;
        bit          exp_err;

        n        = ld_words.size();
        sum      = '0;
        done_cyc = 0;
        got_done = 1'b0;
        foreach (ld_words[i]) sum += ld_words[i];
        exp_lat  = 5 * n;
        exp_err  = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        if (n > 0) begin
            exp_lat = exp_lat + 4;
            exp_err = bad_sum;
        end
`endif
        obs_addr.delete();
        obs_data.delete();
        done_cnt   = 0;
        iBaseAddr  = base;
        iWordCount = CW'(n);
        iStart     = 1'b1;

        fork
            begin
                foreach (ld_words[i])
                    for (int k = 0; k < 4; k++)
                        send_byte(ld_words[i][8*k +: 8], int'($urandom_range(max_gap, 0)));
`ifdef LOADER_CHECKSUM_EN
                if (n > 0) begin
                    logic [31:0] s;
                    s = sum + (bad_sum ? 32'd1 : 32'd0);
                    for (int k = 0; k < 4; k++)
                        send_byte(s[8*k +: 8], int'($urandom_range(max_gap, 0)));
                end
`endif
            end
            begin
                @(posedge iClk);
                #1;
                start_cyc  = cyc;
                iStart     = 1'b0;
                iBaseAddr  = $urandom;
                iWordCount = CW'($urandom);
                @(negedge iClk);
                chk("cksum_clr", 64'(oChecksumErr), 64'd0);
                for (int i = 0; i < 4000; i++) begin
                    if (oDone) begin
                        got_done = 1'b1;
                        done_cyc = cyc;
                        break;
                    end
                    @(negedge iClk);
                end
                chk("done_seen", 64'(got_done), 64'd1);
                chk("cksum_err", 64'(oChecksumErr), 64'(exp_err));
                if (max_gap == 0)
                    chk("done_lat", 64'(done_cyc - start_cyc), 64'(exp_lat));
                @(negedge iClk);
                chk("busy_after", 64'(oBusy), 64'd0);
                chk("hold_after", 64'(oCpuHold), 64'd0);
                chk("done_pulses", 64'(done_cnt), 64'd1);
            end
            begin
                if (poke_start && n > 0) begin
                    repeat (3) @(posedge iClk);
                    #2;
                    iStart = 1'b1;
                    @(posedge iClk);
                    #2;
                    iStart = 1'b0;
                end
            end
        join

        chk("n_writes", 64'(obs_addr.size()), 64'(n));
        for (int i = 0; i < n && i < obs_addr.size(); i++) begin
            exp_addr = (base & 32'hFFFF_FFFC) + 32'(4 * i);
            chk($sformatf("wr_addr[%0d]", i), 64'(obs_addr[i]), 64'(exp_addr));
            chk($sformatf("wr_data[%0d]", i), 64'(obs_data[i]), 64'(ld_words[i]));
        end
    endtask

    initial begin
        int n;
        logic [31:0] w0;
        logic [31:0] w1;

        // Reset state
        repeat (3) @(posedge iClk);
        @(negedge iClk);
        check_all_zero("rst");
        @(posedge iClk);
        #1;
        iRst = 1'b0;
        repeat (2) @(posedge iClk);
        #1;

        // Basic two-word load with valid held high
        ld_words = {32'h0050_0093, 32'h00A0_0113};
        run_load(32'h0, 0, 1'b0, 1'b0);

        // Same words with gaps between bytes and a stray start mid-load
        run_load(32'h0, 3, 1'b0, 1'b1);

        // Zero-length load
        ld_words.delete();
        run_load(32'h40, 0, 1'b0, 1'b0);

        // Address wrap-around, unaligned base bits ignored
        ld_words = {$urandom, $urandom};
        run_load(32'hFFFF_FFFC, 0, 1'b0, 1'b0);
        run_load(32'hFFFF_FFFF, 1, 1'b0, 1'b0);

        // Checksum good, then bad, then cleared by the next start
        ld_words = {32'h1, 32'h2};
        run_load(32'h200, 0, 1'b0, 1'b0);
        run_load(32'h200, 0, 1'b1, 1'b0);
        ld_words.delete();
        run_load(32'h0, 0, 1'b0, 1'b0);

        // Reset after byte 2 of word 1: partial word dropped
        w0 = 32'hDEAD_BEEF;
        w1 = 32'h1234_5678;
        obs_addr.delete();
        obs_data.delete();
        iBaseAddr  = 32'h100;
        iWordCount = 16'd2;
        iStart     = 1'b1;
        @(posedge iClk);
        #1;
        iStart = 1'b0;
        for (int k = 0; k < 4; k++) send_byte(w0[8*k +: 8], 0);
        for (int k = 0; k < 3; k++) send_byte(w1[8*k +: 8], 0);
        iRst = 1'b1;
        @(posedge iClk);
        @(negedge iClk);
        check_all_zero("midrst");
        @(posedge iClk);
        #1;
        iRst = 1'b0;
        repeat (6) @(posedge iClk);
        #1;
        chk("midrst_nwrites", 64'(obs_addr.size()), 64'd1);
        if (obs_addr.size() > 0) begin
            chk("midrst_addr", 64'(obs_addr[0]), 64'h100);
            chk("midrst_data", 64'(obs_data[0]), 64'(w0));
        end

        // Fresh load after the aborted one
        ld_words = {32'hCAFE_F00D, 32'h0BAD_C0DE, 32'h0000_0013};
        run_load(32'h300, 0, 1'b0, 1'b0);

        // Randomised loads
        for (int t = 0; t < 10; t++) begin
            n = int'($urandom_range(5, 0));
            ld_words.delete();
            for (int i = 0; i < n; i++) ld_words.push_back($urandom);
            run_load($urandom, int'($urandom_range(2, 0)), 1'($urandom_range(1, 0)),
                     1'($urandom_range(1, 0)));
            repeat (int'($urandom_range(3, 0))) @(posedge iClk);
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_instr_mem_loader
`default_nettype wire

// File: doc/instr_mem_loader.md
# instr_mem_loader

Write-side master for the instruction memory: accepts a byte stream after a start command, assembles little-endian 32-bit instruction words, and writes them sequentially into the instruction memory write port. It is the writer counterpart to the instruction fetch read path that feeds the control path. While loading, it holds the CPU off via `oCpuHold`.

## Interface
- `ADDR_WIDTH`, 32: width of the memory byte address.
- `COUNT_WIDTH`, 16: width of the word-count field.

- `iClk` in 1: clock, rising edge.
- `iRst` in 1: synchronous, active-high reset.
- `iStart` in 1: one-cycle load command. Sampled only in IDLE.
- `iBaseAddr` in ADDR_WIDTH: byte address of the first word, captured with `iStart`. Bits [1:0] are ignored and treated as 0.
- `iWordCount` in COUNT_WIDTH: number of words to load, captured with `iStart`.
- `iByte` in 8: stream data byte.
- `iByteValid` in 1: `iByte` is valid.
- `oByteReady` out 1: the loader can accept a byte.
- `oMemWe` out 1: instruction memory write enable, one cycle per word.
- `oMemAddr` out ADDR_WIDTH: write byte address, word aligned.
- `oMemWData` out 32: assembled instruction word.
- `oBusy` out 1: high in every state except IDLE.
- `oCpuHold` out 1: equals `oBusy`; stalls or holds the CPU during a load.
- `oDone` out 1: one-cycle pulse when the load completes.
- `oChecksumErr` out 1: checksum mismatch flag. Sticky until the next accepted `iStart`.

## Operation
- **Reset values.** All outputs are 0. State is IDLE. Byte index, word counter, address, and checksum accumulator are 0.
- **State machine.** States are IDLE, COLLECT, WRITE, CHECK (macro only), and DONE.
- **IDLE.**
  - On `iStart`, capture base address and count, and clear `oChecksumErr`.
  - If count is 0, go to DONE. Otherwise go to COLLECT.
- **Byte handshake.** A byte is accepted when `iByteValid && oByteReady`.
  - `oByteReady` is 1 only in COLLECT and CHECK.
  - `iByteValid` may stay high across cycles with no limit; no byte is lost or duplicated.
- **COLLECT.**
  - Accepted byte k (0..3) goes to bits [8k+7:8k]; the first byte is the LSB.
  - On acceptance of byte 3, go to WRITE.
- **WRITE.**
  - Exactly one cycle: `oMemWe`=1, `oMemAddr` = base + 4·wordIndex, `oMemWData` = assembled word.
  - Then increment wordIndex.
  - If wordIndex+1 == count, go to CHECK (macro) or DONE. Otherwise go to COLLECT.
- **DONE.** `oDone`=1 for one cycle, then IDLE.
- **Address arithmetic.** Modulo 2^ADDR_WIDTH; wrap-around is silent.
- **Start while busy.** `iStart` outside IDLE is ignored.
- **Reset mid-load.** The partial word is discarded and no write is issued. Words already written stay in memory.
- **Outside WRITE.** `oMemAddr` and `oMemWData` hold their last values; only `oMemWe` is qualified.

## Timing
- Minimum time per word is 5 cycles: 4 byte-accept cycles plus 1 WRITE cycle.
- `oMemWe` rises in the cycle after byte 3 is accepted.
- `oDone` rises in the cycle after the final WRITE (no macro) or after the last checksum byte (macro).
- With `iWordCount`=0: `iStart` at cycle 0 gives DONE at cycle 1 and `oDone` high during cycle 1.
- `oBusy` and `oCpuHold` rise in the cycle after `iStart` and fall in the cycle after DONE.

## Configuration
- **`LOADER_CHECKSUM_EN` defined.**
  - Each written word is added to a 32-bit accumulator, mod 2^32.
  - After the last word, CHECK accepts 4 more bytes (little-endian) as the expected sum. No memory write is issued for them.
  - On a mismatch, `oChecksumErr` is set in the DONE cycle. `oDone` still pulses.
  - A count of 0 skips CHECK.
- **`LOADER_CHECKSUM_EN` undefined.** No CHECK state and no accumulator; `oChecksumErr` is tied to 0.

## Structure
- **Shared package `LoaderTypes`.**
  - State enum `LoaderState_t` {IDLE, COLLECT, WRITE, CHECK, DONE}.
  - Constant `BYTES_PER_WORD` = 4.
- **Sub-module `word_assembler`.**
  - Byte shift-in register with a 2-bit index.
  - Outputs the assembled word and a `oWordValid` strobe on the 4th byte.
  - Has a clear input driven by reset and by `iStart`.
  - Reused by the CHECK state.

## Test plan
- Reset, then `iStart` with base 0x0, count 2; bytes 93 00 50 00, then 13 01 A0 00 with valid held high → writes 0x00500093 @0x0 and 0x00A00113 @0x4, then `oDone` one pulse, `oBusy`=0.
- Gaps in `iByteValid` (valid low 3 cycles between bytes) → same writes, no duplicates; `oByteReady`=0 during WRITE.
- `iStart` with count 0 → `oDone` in the next cycle, no `oMemWe`.
- Base 0xFFFFFFFC, count 2 → writes at 0xFFFFFFFC and then 0x00000000.
- `iRst` asserted after byte 2 of word 1 → all outputs 0 next cycle, no write. A fresh load afterwards completes correctly.
- Checksum (macro): words 0x1, 0x2 with checksum 0x3 → `oChecksumErr`=0. Same words with checksum 0x4 → `oChecksumErr`=1, cleared by the next `iStart`.
